// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard front end for the MC-10 key matrix.
// Filters and deserialises frames, tracks E0/F0 prefixes, holds the matrix code.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       scan_strobe,
  output logic [7:0] scan_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_done;
  logic          fall;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          par_ok;
  logic [TW-1:0] to_cnt;

  logic          brk;
  logic          ext;
  logic [6:0]    map_ent;
  logic          map_hit;
  logic [2:0]    map_col;
  logic [2:0]    map_row;
  logic          is_e0;
  logic          is_f0;
  logic          is_shift;
  logic          is_ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  assign filt_done = (filt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_done) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Fall fires on the same clk the filter accepts the low level.
  assign fall = clk_filt & ~clk_s & filt_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_idx     <= '0;
      par_ok      <= 1'b0;
      to_cnt      <= '0;
      scan_strobe <= 1'b0;
      scan_byte   <= '0;
      frame_err   <= 1'b0;
    end else begin
      scan_strobe <= 1'b0;
      frame_err   <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (dat_s) begin
              frame_err <= 1'b1;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{shreg, dat_s};
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (par_ok && dat_s) begin
              scan_strobe <= 1'b1;
              scan_byte   <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

  // Entry is {hit, col, row}, written in octal so each digit is one field.
  function automatic logic [6:0] key_map(input logic [7:0] sc);
    case (sc)
      8'h54: key_map = 7'o100;
      8'h1C: key_map = 7'o101;
      8'h32: key_map = 7'o102;
      8'h21: key_map = 7'o103;
      8'h23: key_map = 7'o104;
      8'h24: key_map = 7'o105;
      8'h2B: key_map = 7'o106;
      8'h34: key_map = 7'o107;
      8'h33: key_map = 7'o110;
      8'h43: key_map = 7'o111;
      8'h3B: key_map = 7'o112;
      8'h42: key_map = 7'o113;
      8'h4B: key_map = 7'o114;
      8'h3A: key_map = 7'o115;
      8'h31: key_map = 7'o116;
      8'h44: key_map = 7'o117;
      8'h4D: key_map = 7'o120;
      8'h15: key_map = 7'o121;
      8'h2D: key_map = 7'o122;
      8'h1B: key_map = 7'o123;
      8'h2C: key_map = 7'o124;
      8'h3C: key_map = 7'o125;
      8'h2A: key_map = 7'o126;
      8'h1D: key_map = 7'o127;
      8'h22: key_map = 7'o130;
      8'h35: key_map = 7'o131;
      8'h1A: key_map = 7'o132;
      8'h66: key_map = 7'o135;
      8'h29: key_map = 7'o137;
      8'h45: key_map = 7'o140;
      8'h16: key_map = 7'o141;
      8'h1E: key_map = 7'o142;
      8'h26: key_map = 7'o143;
      8'h25: key_map = 7'o144;
      8'h2E: key_map = 7'o145;
      8'h36: key_map = 7'o146;
      8'h3D: key_map = 7'o147;
      8'h3E: key_map = 7'o150;
      8'h46: key_map = 7'o151;
      8'h52: key_map = 7'o152;
      8'h4C: key_map = 7'o153;
      8'h41: key_map = 7'o154;
      8'h4E: key_map = 7'o155;
      8'h49: key_map = 7'o156;
      8'h4A: key_map = 7'o157;
      8'h5A: key_map = 7'o160;
      default: key_map = 7'o000;
    endcase
  endfunction

  assign map_ent  = key_map(scan_byte);
  assign map_hit  = map_ent[6];
  assign map_col  = map_ent[5:3];
  assign map_row  = map_ent[2:0];
  assign is_e0    = (scan_byte == 8'hE0);
  assign is_f0    = (scan_byte == 8'hF0);
  assign is_shift = (scan_byte == 8'h12) || (scan_byte == 8'h59);
  assign is_ctrl  = (scan_byte == 8'h14);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_code <= 8'hFF;
      brk      <= 1'b0;
      ext      <= 1'b0;
    end else if (frame_err) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (scan_strobe) begin
      unique case (1'b1)
        is_e0: ext <= 1'b1;
        is_f0: brk <= 1'b1;
        default: begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (is_shift) begin
            key_code[3] <= brk;
          end else if (is_ctrl) begin
            key_code[7] <= brk;
          end else if (map_hit && !ext) begin
            if (!brk) begin
              key_code[6:4] <= map_col;
              key_code[2:0] <= map_row;
            end else if (key_code[6:4] == map_col &&
                         key_code[2:0] == map_row) begin
              key_code[6:4] <= 3'd7;
              key_code[2:0] <= 3'd7;
            end
          end
        end
      endcase
    end
  end

endmodule
